png_put_pixels: RTL and testbench

PNG_PUT_PIXELS -- requirements
Module: png_put_pixels

---
 rtl/png_put_pixels.sv | 166 ++++++++++++++++
 tb/tb_png_put_pixels.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/png_put_pixels.sv
// Packs a raster R,G,B byte stream into 8-pixel block-line words (one 64b word per colour),
// then pads the picture with all-zero lines up to a whole 8-line block row.
module png_put_pixels (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pic_width,
    input  logic [10:0] pic_height,
    input  logic [7:0]  pixel_in_data,
    input  logic        pixel_in_valid,
    output logic        pixel_in_rdy,
    output logic        word_vld,
    input  logic        word_rdy,
    output logic [2:0]  word_line,
    output logic [7:0]  word_xblk,
    output logic [63:0] word_r,
    output logic [63:0] word_g,
    output logic [63:0] word_b,
    output logic        frame_done,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // a producer holds its payload stable while valid is high and ready is low.

    typedef enum logic [1:0] {COLLECT = 2'd0, PADY = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [1:0]  rgb_cnt;
    logic [10:0] x_cnt, y_cnt;
    logic [63:0] stage_r, stage_g, stage_b;
    logic [63:0] stage_r_nxt, stage_g_nxt, stage_b_nxt;
    logic [7:0]  pad_xblk;
    logic        last_word;

    logic [10:0] width_m1, height_m1;
    logic [5:0]  lane_sh;
    logic        in_fire, word_fire, x_last, y_last;
    logic        seg_close, frame_close, pad_load, pad_xlast, pad_last;

    assign width_m1    = pic_width - 11'd1;
    assign height_m1   = pic_height - 11'd1;
    assign pixel_in_rdy = (state == COLLECT) & ~word_vld;
    assign in_fire     = pixel_in_valid & pixel_in_rdy;
    assign word_fire   = word_vld & word_rdy;
    assign x_last      = (x_cnt == width_m1);
    assign y_last      = (y_cnt == height_m1);
    assign seg_close   = in_fire & (rgb_cnt == 2'd2) & ((x_cnt[2:0] == 3'd7) | x_last);
    assign frame_close = seg_close & x_last & y_last;
    assign pad_load    = (state == PADY) & ~word_vld & ~last_word;
    assign pad_xlast   = (pad_xblk == width_m1[10:3]);
    assign pad_last    = pad_xlast & (y_cnt[2:0] == 3'd7);
    assign frame_done  = (state == DONE);
    assign state_dbg   = state;

    // Lane 0 sits in the top byte, so the bit offset is 8*(7-lane) = {~lane, 3'b000}.
    assign lane_sh = {~x_cnt[2:0], 3'b000};

    always_comb begin
        stage_r_nxt = stage_r;
        stage_g_nxt = stage_g;
        stage_b_nxt = stage_b;
        if (in_fire) begin
            case (rgb_cnt)
                2'd0:    stage_r_nxt[lane_sh +: 8] = pixel_in_data;
                2'd1:    stage_g_nxt[lane_sh +: 8] = pixel_in_data;
                2'd2:    stage_b_nxt[lane_sh +: 8] = pixel_in_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (frame_close && (pic_height[2:0] != 3'd0))
                    state_nxt = PADY;
                else if (word_fire && last_word)
                    state_nxt = DONE;
            end
            PADY:    if (word_fire && last_word) state_nxt = DONE;
            DONE:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_cnt   <= 2'd0;
            x_cnt     <= 11'd0;
            y_cnt     <= 11'd0;
            stage_r   <= 64'd0;
            stage_g   <= 64'd0;
            stage_b   <= 64'd0;
            pad_xblk  <= 8'd0;
            last_word <= 1'b0;
            word_vld  <= 1'b0;
            word_line <= 3'd0;
            word_xblk <= 8'd0;
            word_r    <= 64'd0;
            word_g    <= 64'd0;
            word_b    <= 64'd0;
        end else if (state == DONE) begin
            rgb_cnt   <= 2'd0;
            x_cnt     <= 11'd0;
            y_cnt     <= 11'd0;
            pad_xblk  <= 8'd0;
            last_word <= 1'b0;
        end else begin
            if (in_fire) begin
                rgb_cnt <= (rgb_cnt == 2'd2) ? 2'd0 : rgb_cnt + 2'd1;
                if (rgb_cnt == 2'd2) begin
                    if (x_last) begin
                        x_cnt <= 11'd0;
                        y_cnt <= y_cnt + 11'd1;
                    end else begin
                        x_cnt <= x_cnt + 11'd1;
                    end
                end
            end

            // Clearing on close leaves unused tail lanes of the last block column at zero.
            if (seg_close) begin
                stage_r <= 64'd0;
                stage_g <= 64'd0;
                stage_b <= 64'd0;
            end else begin
                stage_r <= stage_r_nxt;
                stage_g <= stage_g_nxt;
                stage_b <= stage_b_nxt;
            end

            if (seg_close) begin
                word_vld  <= 1'b1;
                word_line <= y_cnt[2:0];
                word_xblk <= x_cnt[10:3];
                word_r    <= stage_r_nxt;
                word_g    <= stage_g_nxt;
                word_b    <= stage_b_nxt;
                last_word <= frame_close & (pic_height[2:0] == 3'd0);
            end else if (pad_load) begin
                word_vld  <= 1'b1;
                word_line <= y_cnt[2:0];
                word_xblk <= pad_xblk;
                word_r    <= 64'd0;
                word_g    <= 64'd0;
                word_b    <= 64'd0;
                last_word <= pad_last;
                if (pad_xlast) begin
                    pad_xblk <= 8'd0;
                    y_cnt    <= y_cnt + 11'd1;
                end else begin
                    pad_xblk <= pad_xblk + 8'd1;
                end
            end else if (word_fire) begin
                word_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_png_put_pixels.sv
// Directed bench for png_put_pixels: raster reference model feeding an expected-word queue,
// hand-computed word values for the small frames, stall, mid-frame reset and random flow control.
module tb_png_put_pixels;

    localparam int WW = 3 + 8 + 64 * 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] pic_width, pic_height;
    logic [7:0]  pixel_in_data;
    logic        pixel_in_valid;
    logic        pixel_in_rdy;
    logic        word_vld;
    logic        word_rdy;
    logic [2:0]  word_line;
    logic [7:0]  word_xblk;
    logic [63:0] word_r, word_g, word_b;
    logic        frame_done;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    bit sb_en = 1'b0;

    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] got_q[$];
    logic [WW-1:0] ref_q[$];
    logic [7:0]    byte_q[$];
    logic [WW-1:0] mon_w, mon_e;

    png_put_pixels dut (
        .clk            (clk),
        .rst            (rst),
        .pic_width      (pic_width),
        .pic_height     (pic_height),
        .pixel_in_data  (pixel_in_data),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in_rdy   (pixel_in_rdy),
        .word_vld       (word_vld),
        .word_rdy       (word_rdy),
        .word_line      (word_line),
        .word_xblk      (word_xblk),
        .word_r         (word_r),
        .word_g         (word_g),
        .word_b         (word_b),
        .frame_done     (frame_done),
        .state_dbg      (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] f_id(input logic [WW-1:0] w);
        return {53'd0, w[202:192]};
    endfunction
    function automatic logic [63:0] f_r(input logic [WW-1:0] w);
        return w[191:128];
    endfunction
    function automatic logic [63:0] f_g(input logic [WW-1:0] w);
        return w[127:64];
    endfunction
    function automatic logic [63:0] f_b(input logic [WW-1:0] w);
        return w[63:0];
    endfunction

    // word_rdy driver: 0 always ready, 1 random, 2 held low
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       word_rdy = 1'b1;
            1:       word_rdy = ($urandom_range(0, 3) != 0);
            default: word_rdy = 1'b0;
        endcase
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (word_vld && word_rdy) begin
                mon_w = {word_line, word_xblk, word_r, word_g, word_b};
                got_q.push_back(mon_w);
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", f_id(mon_w), 64'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_line_xblk", f_id(mon_w), f_id(mon_e));
                    check("word_r", f_r(mon_w), f_r(mon_e));
                    check("word_g", f_g(mon_w), f_g(mon_e));
                    check("word_b", f_b(mon_w), f_b(mon_e));
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
            end
        end
    end

    // reference model: raster over padded picture, tail lanes and pad lines zero
    task automatic build_exp(input int w, input int h);
        int xb, yb, x, idx;
        logic [63:0] r, g, b;
        xb = (w + 7) / 8;
        yb = (h + 7) / 8;
        for (int y = 0; y < 8 * yb; y++) begin
            for (int k = 0; k < xb; k++) begin
                r = '0; g = '0; b = '0;
                for (int l = 0; l < 8; l++) begin
                    x = 8 * k + l;
                    if (x < w && y < h) begin
                        idx = (y * w + x) * 3;
                        r[63 - 8 * l -: 8] = byte_q[idx];
                        g[63 - 8 * l -: 8] = byte_q[idx + 1];
                        b[63 - 8 * l -: 8] = byte_q[idx + 2];
                    end
                end
                exp_q.push_back({3'(y), 8'(k), r, g, b});
            end
        end
    endtask

    task automatic fill_seq(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // driver: call just after a rising edge; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] d, input int gap_max);
        int t;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        pixel_in_data  = d;
        pixel_in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!pixel_in_rdy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!pixel_in_rdy) check("input_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        pixel_in_valid = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int gap_max);
        int t;
        exp_q.delete();
        got_q.delete();
        done_cnt   = 0;
        pic_width  = 11'(w);
        pic_height = 11'(h);
        build_exp(w, h);
        sb_en = 1'b1;
        for (int i = 0; i < byte_q.size(); i++) send_byte(byte_q[i], gap_max);
        t = 0;
        while ((exp_q.size() != 0 || done_cnt == 0) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("frame_done_count", 64'(done_cnt), 64'd1);
    endtask

    task automatic check_8x8_words(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            check({tag, "_w0_r"}, f_r(got_q[0]), 64'h00030609_0C0F1215);
            check({tag, "_w0_g"}, f_g(got_q[0]), 64'h0104070A_0D101316);
            check({tag, "_w0_b"}, f_b(got_q[0]), 64'h0205080B_0E111417);
            check({tag, "_w7_id"}, f_id(got_q[7]), {53'd0, 3'd7, 8'd0});
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] snap_r, snap_g, snap_b, snap_id;

    initial begin
        rst            = 1'b1;
        pixel_in_valid = 1'b0;
        pixel_in_data  = 8'd0;
        pic_width      = 11'd8;
        pic_height     = 11'd8;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel_in_rdy", 64'(pixel_in_rdy), 64'd1);
        check("rst_word_vld", 64'(word_vld), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_word_id", {53'd0, word_line, word_xblk}, 64'd0);
        check("rst_word_r", word_r, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 8x8 sequential bytes, always ready
        fill_seq(192);
        run_frame(8, 8, 0);
        check_8x8_words("f8x8");

        // 10x3: two block columns, partial second column, then vertical pad
        fill_rand(90);
        run_frame(10, 3, 1);
        check("f10x3_count", 64'(got_q.size()), 64'd16);
        if (got_q.size() == 16) begin
            check("f10x3_w1_id", f_id(got_q[1]), {53'd0, 3'd0, 8'd1});
            check("f10x3_w1_r_tail", {16'd0, got_q[1][175:128]}, 64'd0);
            check("f10x3_w1_b_tail", {16'd0, got_q[1][47:0]}, 64'd0);
            check("f10x3_w6_id", f_id(got_q[6]), {53'd0, 3'd3, 8'd0});
            check("f10x3_w6_r", f_r(got_q[6]), 64'd0);
            check("f10x3_w15_id", f_id(got_q[15]), {53'd0, 3'd7, 8'd1});
        end

        // 16x8 reference run, then the same stream with a 20-cycle stall at the first word
        fill_seq(384);
        run_frame(16, 8, 0);
        ref_q = got_q;
        rdy_mode = 2;
        fork
            run_frame(16, 8, 0);
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!word_vld && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                check("stall_vld_seen", 64'(word_vld), 64'd1);
                snap_id = {53'd0, word_line, word_xblk};
                snap_r  = word_r;
                snap_g  = word_g;
                snap_b  = word_b;
                repeat (20) begin
                    @(negedge clk);
                    check("stall_vld_hold", 64'(word_vld), 64'd1);
                    check("stall_in_rdy_low", 64'(pixel_in_rdy), 64'd0);
                    check("stall_id_hold", {53'd0, word_line, word_xblk}, snap_id);
                    check("stall_r_hold", word_r, snap_r);
                    check("stall_g_hold", word_g, snap_g);
                    check("stall_b_hold", word_b, snap_b);
                end
                rdy_mode = 0;
            end
        join
        check("stall_count", 64'(got_q.size()), 64'(ref_q.size()));
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
            check("stall_seq_id", f_id(got_q[i]), f_id(ref_q[i]));
            check("stall_seq_r", f_r(got_q[i]), f_r(ref_q[i]));
            check("stall_seq_b", f_b(got_q[i]), f_b(ref_q[i]));
        end

        // 1x1 frame
        byte_q.delete();
        byte_q.push_back(8'hAA);
        byte_q.push_back(8'hBB);
        byte_q.push_back(8'hCC);
        run_frame(1, 1, 0);
        check("f1x1_count", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            check("f1x1_w0_r", f_r(got_q[0]), 64'hAA000000_00000000);
            check("f1x1_w0_g", f_g(got_q[0]), 64'hBB000000_00000000);
            check("f1x1_w0_b", f_b(got_q[0]), 64'hCC000000_00000000);
            check("f1x1_w1_id", f_id(got_q[1]), {53'd0, 3'd1, 8'd0});
            check("f1x1_w7_g", f_g(got_q[7]), 64'd0);
        end

        // reset after 100 bytes of a 16x16 frame, then a clean 8x8 frame
        sb_en      = 1'b0;
        pic_width  = 11'd16;
        pic_height = 11'd16;
        for (int i = 0; i < 100; i++) send_byte(8'(i + 77), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_word_vld", 64'(word_vld), 64'd0);
        check("midrst_in_rdy", 64'(pixel_in_rdy), 64'd1);
        check("midrst_word_r", word_r, 64'd0);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("postrst_word_vld", 64'(word_vld), 64'd0);
        fill_seq(192);
        run_frame(8, 8, 0);
        check_8x8_words("after_rst");

        // 37x21 with random input gaps and random word_rdy
        rdy_mode = 1;
        fill_rand(37 * 21 * 3);
        run_frame(37, 21, 2);
        check("f37x21_count", 64'(got_q.size()), 64'd120);
        rdy_mode = 0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
